// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer.
//   fetch_state_t : sequencer state encoding
//   RESET_PC      : default PC after reset
//   OPCODE_HLT    : default instr[15:12] value that halts fetch
//   PC_WIDTH, INSTR_WIDTH : datapath widths
//   pc_inc / align_pc / is_hlt : small PC and decode helpers
package fetch_pkg;

    localparam int PC_WIDTH    = 16;
    localparam int INSTR_WIDTH = 16;

    localparam logic [PC_WIDTH-1:0] RESET_PC   = 16'h0000;
    localparam logic [3:0]          OPCODE_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;

    // Next sequential instruction address; wraps naturally at 2^16.
    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return pc + 16'd2;
    endfunction

    // Instructions are halfword aligned, so bit 0 of any target is forced low.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:1], 1'b0};
    endfunction

    // True when the instruction's major opcode matches the halt opcode.
    function automatic logic is_hlt(input logic [INSTR_WIDTH-1:0] instr,
                                    input logic [3:0]             opcode);
        return (instr[INSTR_WIDTH-1:INSTR_WIDTH-4] == opcode);
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer holding an instruction and its PC that completed while
// decode was stalled.
//   clk, rst              : clock, async active-high reset
//   load                  : capture load_instr/load_pc, mark valid
//   clear                 : drop the entry (wins over load)
//   load_instr, load_pc   : data to capture
//   buf_valid             : entry present
//   buf_instr, buf_pc     : stored instruction and its address
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic [INSTR_WIDTH-1:0] load_instr,
    input  logic [PC_WIDTH-1:0]    load_pc,
    output logic                   buf_valid,
    output logic [INSTR_WIDTH-1:0] buf_instr,
    output logic [PC_WIDTH-1:0]    buf_pc
);

    logic                   valid_r;
    logic [INSTR_WIDTH-1:0] instr_r;
    logic [PC_WIDTH-1:0]    pc_r;

    // Buffer storage: clear has priority so a redirect always drops the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            instr_r <= 16'h0000;
            pc_r    <= 16'h0000;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= load_instr;
            pc_r    <= load_pc;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign buf_valid = valid_r;
    assign buf_instr = instr_r;
    assign buf_pc    = pc_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter sequencer and instruction-memory fetch for the core.
// Issues one fetch at a time over imem_req/imem_ready, delivers instructions
// to decode honouring stall, applies branch redirects (also while a fetch is
// outstanding) and stops on HLT.
//   clk, rst                     : clock, async active-high reset
//   stall                        : decode cannot accept this cycle
//   redirect_valid, redirect_pc  : taken branch and its target
//   imem_req, imem_addr          : fetch request and address (= pc)
//   imem_ready, imem_rdata       : request completion and instruction word
//   if_valid, if_instr, if_pc    : one-cycle delivery to decode
//   if_pc_plus_two               : if_pc + 2
//   halted                       : HLT delivered, fetch stopped
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = fetch_pkg::RESET_PC,
    parameter logic [3:0]  OPCODE_HLT = fetch_pkg::OPCODE_HLT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [PC_WIDTH-1:0]    if_pc_plus_two,
    output logic                   halted
);

    fetch_state_t           state_r, state_nxt;
    logic [PC_WIDTH-1:0]    pc_r, pc_nxt;
    logic [PC_WIDTH-1:0]    target_r, target_nxt;
    logic                   imem_req_r;
    logic                   if_valid_r;
    logic [INSTR_WIDTH-1:0] if_instr_r;
    logic [PC_WIDTH-1:0]    if_pc_r;
    logic [PC_WIDTH-1:0]    if_pc_plus_two_r;
    logic                   halted_r;

    logic [PC_WIDTH-1:0]    redir_pc_s;
    logic                   deliver_s;
    logic [INSTR_WIDTH-1:0] deliver_instr_s;
    logic [PC_WIDTH-1:0]    deliver_pc_s;
    logic                   buf_load_s;
    logic                   buf_clear_s;
    logic                   buf_valid_s;
    logic [INSTR_WIDTH-1:0] buf_instr_s;
    logic [PC_WIDTH-1:0]    buf_pc_s;

    assign redir_pc_s = align_pc(redirect_pc);

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load_s),
        .clear      (buf_clear_s),
        .load_instr (imem_rdata),
        .load_pc    (pc_r),
        .buf_valid  (buf_valid_s),
        .buf_instr  (buf_instr_s),
        .buf_pc     (buf_pc_s)
    );

    // Next-state, PC and delivery decisions; redirect > delivery > stall.
    always_comb begin
        state_nxt       = state_r;
        pc_nxt          = pc_r;
        target_nxt      = target_r;
        deliver_s       = 1'b0;
        deliver_instr_s = imem_rdata;
        deliver_pc_s    = pc_r;
        buf_load_s      = 1'b0;
        buf_clear_s     = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_nxt = redir_pc_s;
                end else if (!stall) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_IDLE;
                end
            end

            S_FETCH: begin
                if (!imem_ready) begin
                    // The request cannot be retracted; remember the target
                    // and let the old fetch finish in S_DRAIN.
                    if (redirect_valid) begin
                        target_nxt = redir_pc_s;
                        state_nxt  = S_DRAIN;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end else if (redirect_valid) begin
                    pc_nxt    = redir_pc_s;
                    state_nxt = S_IDLE;
                end else if (!stall) begin
                    deliver_s = 1'b1;
                    if (is_hlt(imem_rdata, OPCODE_HLT)) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt    = pc_inc(pc_r);
                        state_nxt = S_FETCH;
                    end
                end else begin
                    buf_load_s = 1'b1;
                    pc_nxt     = pc_inc(pc_r);
                    state_nxt  = S_HOLD;
                end
            end

            S_DRAIN: begin
                if (redirect_valid) begin
                    target_nxt = redir_pc_s;
                end else begin
                    target_nxt = target_r;
                end
                if (imem_ready) begin
                    pc_nxt    = redirect_valid ? redir_pc_s : target_r;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_DRAIN;
                end
            end

            S_HOLD: begin
                deliver_instr_s = buf_instr_s;
                deliver_pc_s    = buf_pc_s;
                if (redirect_valid) begin
                    buf_clear_s = 1'b1;
                    pc_nxt      = redir_pc_s;
                    state_nxt   = S_IDLE;
                end else if (!buf_valid_s) begin
                    // Nothing parked: resume fetching at the current PC.
                    state_nxt = S_FETCH;
                end else if (!stall) begin
                    deliver_s   = 1'b1;
                    buf_clear_s = 1'b1;
                    if (is_hlt(buf_instr_s, OPCODE_HLT)) begin
                        pc_nxt    = buf_pc_s;
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end else begin
                    state_nxt = S_HOLD;
                end
            end

            S_HALT: begin
                // Only a redirect (older branch squashing the HLT) restarts.
                if (redirect_valid) begin
                    pc_nxt    = redir_pc_s;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_HALT;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, PC and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= S_IDLE;
            pc_r             <= RESET_PC;
            target_r         <= 16'h0000;
            imem_req_r       <= 1'b0;
            if_valid_r       <= 1'b0;
            if_instr_r       <= 16'h0000;
            if_pc_r          <= 16'h0000;
            if_pc_plus_two_r <= 16'h0002;
            halted_r         <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            pc_r       <= pc_nxt;
            target_r   <= target_nxt;
            imem_req_r <= (state_nxt == S_FETCH) || (state_nxt == S_DRAIN);
            if_valid_r <= deliver_s;
            halted_r   <= (state_nxt == S_HALT);
            if (deliver_s) begin
                if_instr_r       <= deliver_instr_s;
                if_pc_r          <= deliver_pc_s;
                if_pc_plus_two_r <= pc_inc(deliver_pc_s);
            end else begin
                if_instr_r       <= if_instr_r;
                if_pc_r          <= if_pc_r;
                if_pc_plus_two_r <= if_pc_plus_two_r;
            end
        end
    end

    assign imem_req       = imem_req_r;
    assign imem_addr      = pc_r;
    assign if_valid       = if_valid_r;
    assign if_instr       = if_instr_r;
    assign if_pc          = if_pc_r;
    assign if_pc_plus_two = if_pc_plus_two_r;
    assign halted         = halted_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. Memory returns addr ^ A5A0 unless
// a specific word is forced; expected values are hand-derived per cycle.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus_two;
    logic        halted;

    logic        ovr_en;
    logic [15:0] ovr_val;
    int          total;
    int          bad;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus_two (if_pc_plus_two),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: word is a function of the (registered) address.
    initial begin
        imem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            #1;
            imem_rdata = ovr_en ? ovr_val : (imem_addr ^ 16'hA5A0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        imem_ready     = 1'b1;
        ovr_en         = 1'b0;
        ovr_val        = 16'h0000;

        // Reset values
        nxt();
        nxt();
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", {16'd0, if_instr}, 32'h0000);
        check("rst_pc",    {16'd0, if_pc}, 32'h0000);
        check("rst_ppt",   {16'd0, if_pc_plus_two}, 32'h0002);
        check("rst_halt",  {31'd0, halted}, 32'd0);
        check("rst_addr",  {16'd0, imem_addr}, 32'h0000);
        rst = 1'b0;

        // Streaming fetch with zero-wait memory
        nxt();
        check("start_req",  {31'd0, imem_req}, 32'd1);
        check("start_addr", {16'd0, imem_addr}, 32'h0000);
        for (int a = 2; a <= 6; a += 2) begin
            nxt();
            check("str_addr",  {16'd0, imem_addr}, a);
            check("str_valid", {31'd0, if_valid}, 32'd1);
            check("str_pc",    {16'd0, if_pc}, a - 2);
            check("str_instr", {16'd0, if_instr}, (a - 2) ^ 32'hA5A0);
            check("str_ppt",   {16'd0, if_pc_plus_two}, a);
        end

        // Three wait states at 0006
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            check("ws_req",   {31'd0, imem_req}, 32'd1);
            check("ws_addr",  {16'd0, imem_addr}, 32'h0006);
            check("ws_valid", {31'd0, if_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        nxt();
        check("ws_dvalid", {31'd0, if_valid}, 32'd1);
        check("ws_dpc",    {16'd0, if_pc}, 32'h0006);
        check("ws_next",   {16'd0, imem_addr}, 32'h0008);

        // Stall during the completion of 000A
        nxt();
        check("st_pre_addr", {16'd0, imem_addr}, 32'h000A);
        stall   = 1'b1;
        ovr_en  = 1'b1;
        ovr_val = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            nxt();
            check("st_valid", {31'd0, if_valid}, 32'd0);
            check("st_req",   {31'd0, imem_req}, 32'd0);
        end
        stall  = 1'b0;
        ovr_en = 1'b0;
        nxt();
        check("st_dvalid", {31'd0, if_valid}, 32'd1);
        check("st_dinstr", {16'd0, if_instr}, 32'h1234);
        check("st_dpc",    {16'd0, if_pc}, 32'h000A);
        check("st_next",   {16'd0, imem_addr}, 32'h000C);
        check("st_req2",   {31'd0, imem_req}, 32'd1);

        // Redirect while the fetch of 0010 is outstanding
        nxt();
        nxt();
        check("rd_pre_addr", {16'd0, imem_addr}, 32'h0010);
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        for (int i = 0; i < 2; i++) begin
            nxt();
            redirect_valid = 1'b0;
            check("rd_req",   {31'd0, imem_req}, 32'd1);
            check("rd_addr",  {16'd0, imem_addr}, 32'h0010);
            check("rd_valid", {31'd0, if_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        nxt();
        check("rd_discard", {31'd0, if_valid}, 32'd0);
        check("rd_tgt",     {16'd0, imem_addr}, 32'h0040);
        nxt();
        check("rd_req2",  {31'd0, imem_req}, 32'd1);
        check("rd_addr2", {16'd0, imem_addr}, 32'h0040);

        // Redirect on a ready cycle, then HLT at 0020
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0020;
        nxt();
        redirect_valid = 1'b0;
        check("hl_discard", {31'd0, if_valid}, 32'd0);
        check("hl_addr",    {16'd0, imem_addr}, 32'h0020);
        nxt();
        check("hl_req", {31'd0, imem_req}, 32'd1);
        ovr_en  = 1'b1;
        ovr_val = 16'hF123;
        nxt();
        ovr_en = 1'b0;
        check("hl_valid", {31'd0, if_valid}, 32'd1);
        check("hl_instr", {16'd0, if_instr}, 32'hF123);
        check("hl_pc",    {16'd0, if_pc}, 32'h0020);
        check("hl_halt",  {31'd0, halted}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            nxt();
            check("hl_noreq",  {31'd0, imem_req}, 32'd0);
            check("hl_hold",   {16'd0, imem_addr}, 32'h0020);
            check("hl_halted", {31'd0, halted}, 32'd1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0101;
        nxt();
        redirect_valid = 1'b0;
        check("hl_clear", {31'd0, halted}, 32'd0);
        check("hl_raddr", {16'd0, imem_addr}, 32'h0100);
        nxt();
        check("hl_rreq", {31'd0, imem_req}, 32'd1);

        // Wrap from FFFE to 0000
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        nxt();
        redirect_valid = 1'b0;
        check("wr_addr", {16'd0, imem_addr}, 32'hFFFE);
        nxt();
        check("wr_req", {31'd0, imem_req}, 32'd1);
        nxt();
        check("wr_valid", {31'd0, if_valid}, 32'd1);
        check("wr_pc",    {16'd0, if_pc}, 32'hFFFE);
        check("wr_instr", {16'd0, if_instr}, 32'h5A5E);
        check("wr_ppt",   {16'd0, if_pc_plus_two}, 32'h0000);
        check("wr_next",  {16'd0, imem_addr}, 32'h0000);
        nxt();
        check("wr_pc0",  {16'd0, if_pc}, 32'h0000);
        check("wr_ppt0", {16'd0, if_pc_plus_two}, 32'h0002);

        // Asynchronous reset abandons an outstanding request
        imem_ready = 1'b0;
        nxt();
        rst = 1'b1;
        #1;
        check("ar_req",  {31'd0, imem_req}, 32'd0);
        check("ar_addr", {16'd0, imem_addr}, 32'h0000);
        check("ar_ppt",  {16'd0, if_pc_plus_two}, 32'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
